// File: rtl/maxpool_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// maxpool_pkg : shared state encoding, width helpers and signed lane max
// rev 1.0
// ----------------------------------------------------------------------------
package maxpool_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int DEF_MAX_W  = 64;
  localparam int DEF_MAX_H  = 64;
  localparam int LANE_MAX_W = 32;

  // Counter width able to hold the value max_val itself (W and H are stored raw).
  function automatic int cnt_width(input int max_val);
    return $clog2(max_val + 1);
  endfunction

  function automatic int addr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  localparam int DEF_X_W = cnt_width(DEF_MAX_W);
  localparam int DEF_Y_W = cnt_width(DEF_MAX_H);

  function automatic logic signed [LANE_MAX_W-1:0] lane_max(
    input logic signed [LANE_MAX_W-1:0] a,
    input logic signed [LANE_MAX_W-1:0] b
  );
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/maxpool_stream_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// maxpool_stream_if : pixel-in / pooled-pixel-out valid-ready stream pair
// rev 1.0
// ----------------------------------------------------------------------------
interface maxpool_stream_if #(
  parameter int LANES      = 16,
  parameter int DATA_WIDTH = 16
);
  localparam int LW = LANES * DATA_WIDTH;

  logic          in_valid;
  logic          in_ready;
  logic [LW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [LW-1:0] out_data;
  logic          out_last;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );
endinterface
`default_nettype wire

// File: rtl/pool_line_buf.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pool_line_buf : one-row buffer, async read / sync write (read sees old data)
// rev 1.0
// ----------------------------------------------------------------------------
module pool_line_buf #(
  parameter int DEPTH      = 64,
  parameter int WIDTH      = 256,
  parameter int ADDR_WIDTH = 6
) (
  input  wire logic                  clk,
  input  wire logic                  wr_en,
  input  wire logic [ADDR_WIDTH-1:0] wr_addr,
  input  wire logic [WIDTH-1:0]      wr_data,
  input  wire logic [ADDR_WIDTH-1:0] rd_addr,
  output logic      [WIDTH-1:0]      rd_data
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  assign rd_data = mem_q[rd_addr];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

endmodule
`default_nettype wire

// File: rtl/maxpool_stream.sv
`default_nettype none
// ----------------------------------------------------------------------------
// maxpool_stream : streaming 2x2 signed max-pool, stride 2 or stride 1 (edge replicate)
// rev 1.0
// ----------------------------------------------------------------------------
module maxpool_stream
  import maxpool_pkg::*;
#(
  parameter int LANES      = 16,
  parameter int DATA_WIDTH = 16,
  parameter int MAX_W      = DEF_MAX_W,
  parameter int MAX_H      = DEF_MAX_H
) (
  input  wire logic                         clk,
  input  wire logic                         rst_n,
  input  wire logic                         start,
  input  wire logic                         cfg_stride2,
  input  wire logic [cnt_width(MAX_W)-1:0]  cfg_width,
  input  wire logic [cnt_width(MAX_H)-1:0]  cfg_height,
  maxpool_stream_if.slave                   strm,
  output logic                              busy,
  output logic                              done
);

  localparam int LW = LANES * DATA_WIDTH;
  localparam int XW = cnt_width(MAX_W);
  localparam int YW = cnt_width(MAX_H);
  localparam int AW = addr_width(MAX_W);

  function automatic logic [LW-1:0] vmax(input logic [LW-1:0] a, input logic [LW-1:0] b);
    logic [LW-1:0]                 r;
    logic signed [DATA_WIDTH-1:0]  ta;
    logic signed [DATA_WIDTH-1:0]  tb;
    logic signed [LANE_MAX_W-1:0]  m;
    r = '0;
    for (int k = 0; k < LANES; k++) begin
      ta = a[k*DATA_WIDTH +: DATA_WIDTH];
      tb = b[k*DATA_WIDTH +: DATA_WIDTH];
      m  = lane_max(LANE_MAX_W'(ta), LANE_MAX_W'(tb));
      r[k*DATA_WIDTH +: DATA_WIDTH] = m[DATA_WIDTH-1:0];
    end
    return r;
  endfunction

  state_t          state_q,     state_d;
  logic            stride2_q,   stride2_d;
  logic [XW-1:0]   w_q,         w_d;
  logic [YW-1:0]   h_q,         h_d;
  logic [XW-1:0]   x_q,         x_d;
  logic [YW-1:0]   y_q,         y_d;
  logic            pend_q,      pend_d;
  logic            in_done_q,   in_done_d;
  logic [LW-1:0]   prev_q,      prev_d;
  logic            out_valid_q, out_valid_d;
  logic            out_last_q,  out_last_d;
  logic [LW-1:0]   out_data_q,  out_data_d;

  logic            out_free;
  logic            rdy;
  logic            accept;
  logic            pend_go;
  logic            last_col;
  logic            last_row;
  logic            s2_last_x;
  logic            s2_last_y;
  logic [LW-1:0]   h_in;
  logic            lb_we;
  logic [AW-1:0]   lb_addr;
  logic [LW-1:0]   lb_wdata;
  logic [LW-1:0]   lb_rd;

  assign out_free  = !(out_valid_q && !strm.out_ready);
  assign rdy       = (state_q == RUN) && !pend_q && !in_done_q && out_free;
  assign accept    = rdy && strm.in_valid;
  assign last_col  = (x_q == w_q - XW'(1));
  assign last_row  = (y_q == h_q - YW'(1));
  assign s2_last_x = (x_q == (w_q & ~XW'(1)) - XW'(1));
  assign s2_last_y = (y_q == (h_q & ~YW'(1)) - YW'(1));
  // Row 0 of stride 1 only fills the buffer, so its end-of-row step never waits on the output.
  assign pend_go   = (state_q == RUN) && pend_q && ((y_q == '0) || out_free);
  assign h_in      = vmax(prev_q, strm.in_data);
  assign lb_wdata  = pend_q ? prev_q : h_in;

  always_comb begin
    if (state_q == FLUSH)  lb_addr = AW'(x_q);
    else if (stride2_q)    lb_addr = AW'(x_q >> 1);
    else if (pend_q)       lb_addr = AW'(x_q);
    else                   lb_addr = AW'(x_q - XW'(1));
  end

  pool_line_buf #(
    .DEPTH      (MAX_W),
    .WIDTH      (LW),
    .ADDR_WIDTH (AW)
  ) u_line_buf (
    .clk     (clk),
    .wr_en   (lb_we),
    .wr_addr (lb_addr),
    .wr_data (lb_wdata),
    .rd_addr (lb_addr),
    .rd_data (lb_rd)
  );

  always_comb begin
    state_d     = state_q;
    stride2_d   = stride2_q;
    w_d         = w_q;
    h_d         = h_q;
    x_d         = x_q;
    y_d         = y_q;
    pend_d      = pend_q;
    in_done_d   = in_done_q;
    prev_d      = prev_q;
    out_valid_d = out_valid_q && !strm.out_ready;
    out_last_d  = out_last_q && out_valid_d;
    out_data_d  = out_data_q;
    lb_we       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          stride2_d = cfg_stride2;
          w_d       = cfg_width;
          h_d       = cfg_height;
          x_d       = '0;
          y_d       = '0;
          pend_d    = 1'b0;
          in_done_d = 1'b0;
          state_d   = RUN;
        end
      end
      RUN: begin
        if (accept) begin
          prev_d = strm.in_data;
          if (stride2_q) begin
            if (x_q[0] && !y_q[0]) lb_we = 1'b1;
            if (x_q[0] && y_q[0]) begin
              out_valid_d = 1'b1;
              out_data_d  = vmax(lb_rd, h_in);
              out_last_d  = s2_last_x && s2_last_y;
            end
            if (last_col) begin
              x_d = '0;
              y_d = y_q + YW'(1);
              if (last_row) in_done_d = 1'b1;
            end else begin
              x_d = x_q + XW'(1);
            end
          end else begin
            if (x_q != '0) begin
              lb_we = 1'b1;
              if (y_q != '0) begin
                out_valid_d = 1'b1;
                out_data_d  = vmax(lb_rd, h_in);
                out_last_d  = 1'b0;
              end
            end
            if (last_col) pend_d = 1'b1;
            else          x_d    = x_q + XW'(1);
          end
        end
        // Extra end-of-row step: h[W-1] is the last pixel itself.
        if (pend_go) begin
          lb_we  = 1'b1;
          pend_d = 1'b0;
          x_d    = '0;
          if (y_q != '0) begin
            out_valid_d = 1'b1;
            out_data_d  = vmax(lb_rd, prev_q);
            out_last_d  = 1'b0;
          end
          if (last_row) state_d = FLUSH;
          else          y_d     = y_q + YW'(1);
        end
        if (stride2_q && in_done_q && out_free) state_d = DONE;
      end
      FLUSH: begin
        if (out_free) begin
          if (x_q < w_q) begin
            out_valid_d = 1'b1;
            out_data_d  = lb_rd;
            out_last_d  = (x_q == w_q - XW'(1));
            x_d         = x_q + XW'(1);
          end else begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q     <= IDLE;
      stride2_q   <= 1'b0;
      w_q         <= '0;
      h_q         <= '0;
      x_q         <= '0;
      y_q         <= '0;
      pend_q      <= 1'b0;
      in_done_q   <= 1'b0;
      prev_q      <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      stride2_q   <= stride2_d;
      w_q         <= w_d;
      h_q         <= h_d;
      x_q         <= x_d;
      y_q         <= y_d;
      pend_q      <= pend_d;
      in_done_q   <= in_done_d;
      prev_q      <= prev_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
    end
  end

  assign strm.in_ready  = rdy;
  assign strm.out_valid = out_valid_q;
  assign strm.out_data  = out_data_q;
  assign strm.out_last  = out_last_q;
  assign busy           = (state_q != IDLE);
  assign done           = (state_q == DONE);

endmodule
`default_nettype wire

// File: tb/tb_maxpool_stream.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_maxpool_stream : directed frames with hand-computed pooled outputs
// rev 1.0
// ----------------------------------------------------------------------------
module tb_maxpool_stream;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       cfg_stride2;
  logic [3:0] cfg_width;
  logic [3:0] cfg_height;
  logic       busy;
  logic       done;

  maxpool_stream_if #(.LANES(2), .DATA_WIDTH(16)) sif ();

  maxpool_stream #(
    .LANES      (2),
    .DATA_WIDTH (16),
    .MAX_W      (8),
    .MAX_H      (8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .cfg_stride2 (cfg_stride2),
    .cfg_width   (cfg_width),
    .cfg_height  (cfg_height),
    .strm        (sif),
    .busy        (busy),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int pix0 [64];
  int pix1 [64];
  int q0 [$];
  int q1 [$];
  int n_last, last_pos, drops, late, unstable, done_gap;

  int e_s2_l0 [4] = '{5, 7, 13, 15};
  int e_s2_l1 [4] = '{0, -2, -8, -10};
  int e_s1_l0 [9] = '{4, 5, 5, 7, 8, 8, 7, 8, 8};
  int e_5_l0  [4] = '{6, 8, 16, 18};
  int e_5_l1  [4] = '{0, -2, -10, -12};

  logic signed [15:0] o0, o1;
  assign o0 = sif.out_data[15:0];
  assign o1 = sif.out_data[31:16];

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pack(input int i);
    return {16'(pix1[i]), 16'(pix0[i])};
  endfunction

  task automatic fill_ramp4();
    for (int i = 0; i < 16; i++) begin
      pix0[i] = i;
      pix1[i] = -i;
    end
  endtask

  task automatic run_frame(input bit s2, input int w, input int h, input bit toggle);
    int  idx, cyc, hs_cyc;
    bit  got_done, stalled;
    logic [31:0] held;
    idx = 0; cyc = 0; hs_cyc = -100; got_done = 0; stalled = 0; held = '0;
    q0.delete(); q1.delete();
    n_last = 0; last_pos = -1; drops = 0; late = 0; unstable = 0; done_gap = -1;
    cfg_stride2 = s2; cfg_width = 4'(w); cfg_height = 4'(h); start = 1'b1;
    sif.in_valid = 1'b1; sif.in_data = pack(0); sif.out_ready = 1'b1;
    #1;
    chk("idle_in_ready", int'(sif.in_ready), 0);
    @(posedge clk); #1;
    start = 1'b0; cfg_stride2 = !s2; cfg_width = 4'd2; cfg_height = 4'd2;
    while (!got_done && cyc < 600) begin
      sif.in_valid  = 1'b1;
      sif.in_data   = (idx < w*h) ? pack(idx) : 32'h7FFF_7FFF;
      sif.out_ready = toggle ? (cyc % 2 == 0) : 1'b1;
      #1;
      if (stalled && sif.out_data !== held) unstable++;
      if (sif.in_ready) begin
        if (idx < w*h) idx++;
        else           late++;
      end else if (idx < w*h) begin
        drops++;
      end
      if (sif.out_valid && sif.out_ready) begin
        q0.push_back(int'(o0));
        q1.push_back(int'(o1));
        if (sif.out_last) begin
          n_last++;
          last_pos = q0.size() - 1;
          hs_cyc   = cyc;
        end
      end
      stalled = sif.out_valid && !sif.out_ready;
      held    = sif.out_data;
      if (done) begin
        got_done = 1;
        done_gap = cyc - hs_cyc;
      end
      @(posedge clk); #1;
      cyc++;
    end
    sif.in_valid = 1'b0;
    chk("frame_done_seen", int'(got_done), 1);
    chk("busy_after_done", int'(busy), 0);
    chk("done_one_cycle", int'(done), 0);
  endtask

  task automatic check_s2_4x4(input string pfx);
    chk({pfx, "_count"}, q0.size(), 4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("%s_l0_%0d", pfx, i), (i < q0.size()) ? q0[i] : -99999, e_s2_l0[i]);
      chk($sformatf("%s_l1_%0d", pfx, i), (i < q1.size()) ? q1[i] : -99999, e_s2_l1[i]);
    end
    chk({pfx, "_nlast"}, n_last, 1);
    chk({pfx, "_lastpos"}, last_pos, 3);
    chk({pfx, "_done_gap"}, done_gap, 1);
    chk({pfx, "_late"}, late, 0);
    chk({pfx, "_stable"}, unstable, 0);
  endtask

  initial begin
    int idx, cyc, dseen;
    rst_n = 1'b1; start = 1'b0; cfg_stride2 = 1'b0; cfg_width = '0; cfg_height = '0;
    sif.in_valid = 1'b0; sif.in_data = '0; sif.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy",      int'(busy), 0);
    chk("rst_done",      int'(done), 0);
    chk("rst_out_valid", int'(sif.out_valid), 0);
    chk("rst_out_last",  int'(sif.out_last), 0);
    chk("rst_in_ready",  int'(sif.in_ready), 0);
    chk("rst_out_data",  int'(sif.out_data), 0);
    rst_n = 1'b0;
    @(posedge clk); #1;

    // stride 2, 4x4
    fill_ramp4();
    run_frame(1'b1, 4, 4, 1'b0);
    check_s2_4x4("s2");

    // stride 1, 3x3
    for (int i = 0; i < 9; i++) begin
      pix0[i] = i;
      pix1[i] = 0;
    end
    run_frame(1'b0, 3, 3, 1'b0);
    chk("s1_count", q0.size(), 9);
    for (int i = 0; i < 9; i++)
      chk($sformatf("s1_l0_%0d", i), (i < q0.size()) ? q0[i] : -99999, e_s1_l0[i]);
    chk("s1_drops",    drops, 2);
    chk("s1_late",     late, 0);
    chk("s1_nlast",    n_last, 1);
    chk("s1_lastpos",  last_pos, 8);
    chk("s1_done_gap", done_gap, 1);

    // stride 2, 5x5: odd last column/row dropped
    for (int y = 0; y < 5; y++) begin
      for (int x = 0; x < 5; x++) begin
        pix0[x + 5*y] = (x == 4 || y == 4) ? 32767 : x + 5*y;
        pix1[x + 5*y] = (x == 4 || y == 4) ? 32767 : -(x + 5*y);
      end
    end
    run_frame(1'b1, 5, 5, 1'b0);
    chk("s2o_count", q0.size(), 4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("s2o_l0_%0d", i), (i < q0.size()) ? q0[i] : -99999, e_5_l0[i]);
      chk($sformatf("s2o_l1_%0d", i), (i < q1.size()) ? q1[i] : -99999, e_5_l1[i]);
    end
    chk("s2o_nlast",   n_last, 1);
    chk("s2o_lastpos", last_pos, 3);
    chk("s2o_late",    late, 0);

    // stride 2, 4x4 with out_ready toggling
    fill_ramp4();
    run_frame(1'b1, 4, 4, 1'b1);
    check_s2_4x4("s2bp");

    // mixed-sign and all-negative windows
    pix0[0] = -32768; pix0[1] = 32767; pix0[2] = -32768; pix0[3] = -32768;
    pix1[0] = -5;     pix1[1] = -3;    pix1[2] = -9;     pix1[3] = -7;
    run_frame(1'b1, 2, 2, 1'b0);
    chk("mix_count", q0.size(), 1);
    chk("mix_l0", (q0.size() > 0) ? q0[0] : -99999, 32767);
    chk("mix_l1", (q1.size() > 0) ? q1[0] : -99999, -3);
    chk("mix_last", n_last, 1);

    // reset after six beats of a 4x4 frame, then a clean rerun
    fill_ramp4();
    cfg_stride2 = 1'b1; cfg_width = 4'd4; cfg_height = 4'd4; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    idx = 0; cyc = 0; dseen = 0;
    while (idx < 6 && cyc < 100) begin
      sif.in_valid = 1'b1; sif.in_data = pack(idx); sif.out_ready = 1'b1;
      #1;
      if (sif.in_ready) idx++;
      if (done) dseen++;
      @(posedge clk); #1;
      cyc++;
    end
    chk("abort_beats", idx, 6);
    rst_n = 1'b1; sif.in_valid = 1'b0;
    @(posedge clk); #1;
    chk("abort_busy",      int'(busy), 0);
    chk("abort_done",      int'(done), 0);
    chk("abort_out_valid", int'(sif.out_valid), 0);
    chk("abort_no_done",   dseen, 0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    run_frame(1'b1, 4, 4, 1'b0);
    check_s2_4x4("rerun");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/maxpool_stream.md
MAXPOOL_STREAM -- requirements
Module: maxpool_stream

Interface
REQ-001 SHALL have parameter LANES, default 16: independent channels carried per beat.
REQ-002 SHALL have parameter DATA_WIDTH, default 16: signed element width.
REQ-003 SHALL have parameter MAX_W, default 64: maximum frame width and line-buffer depth.
REQ-004 SHALL have parameter MAX_H, default 64: maximum frame height.
REQ-005 clk  in  1  sole clock; all logic on rising edge.
REQ-006 rst_n  in  1  synchronous reset, active-high (codebase port name kept; asserted = 1).
REQ-007 start  in  1  one-cycle pulse; latches cfg_*; ignored unless IDLE.
REQ-008 cfg_stride2  in  1  0 = 2x2 window stride 1 (edge replicate); 1 = 2x2 window stride 2.
REQ-009 cfg_width  in  clog2(MAX_W+1)  frame width W, legal 2..MAX_W.
REQ-010 cfg_height  in  clog2(MAX_H+1)  frame height H, legal 2..MAX_H.
REQ-011 in_valid / in_ready  in / out  1  input handshake; a beat transfers when both are high.
REQ-012 in_data  in  LANES*DATA_WIDTH  one pixel, row-major; lane k at [k*DW +: DW].
REQ-013 out_valid / out_ready  out / in  1  output handshake.
REQ-014 out_data  out  LANES*DATA_WIDTH  pooled pixel, same lane packing.
REQ-015 out_last  out  1  high with the final output pixel of the frame.
REQ-016 busy  out  1  high in every state except IDLE.
REQ-017 done  out  1  one-cycle pulse after the final output handshake.

Function
REQ-018 States: IDLE -> RUN on start; RUN -> FLUSH after the last input beat (stride 1) or straight to DONE after the last output handshake (stride 2); FLUSH -> DONE after the last output handshake; DONE -> IDLE after one cycle, with done = 1 in DONE.
REQ-019 Max is signed two's complement per lane; output element width equals input width; no saturation.
REQ-020 Stride 2: hmax = max(p[2X], p[2X+1]); even rows write hmax to the line buffer; odd rows emit max(linebuf[X], hmax); output size floor(W/2) x floor(H/2); odd last column and odd last row are consumed and dropped.
REQ-021 Stride 1: h[x] = max(p[x], p[x+1]) with p[W] = p[W-1]; out(x,y) = max(h_y[x], h_(y+1)[x]) with h_H = h_(H-1); output size W x H.
REQ-022 Stride 1: column x is emitted when pixel x+1 arrives; at row end, in_ready = 0 for exactly one extra cycle to emit column W-1.
REQ-023 Stride 1: row 0 produces no output; FLUSH emits row H-1 from the line buffer alone, with in_ready = 0.
REQ-024 Output is a single register stage: in_ready = 0 whenever out_valid && !out_ready (backpressure); out_data holds stable while out_valid && !out_ready.
REQ-025 Latency: first output for a row-0 pixel pair is registered on the cycle after the enabling input handshake.
REQ-026 in_ready = 0 in IDLE, FLUSH and DONE; beats offered then are not consumed.
REQ-027 start while busy is ignored; cfg changes after start have no effect until the next start.
REQ-028 out_last is asserted with out_valid on the output pixel at (last col, last row) only.

Reset
REQ-029 On rst_n = 1: state = IDLE; out_valid, out_last, done, busy, in_ready = 0; out_data = 0; x/y counters = 0; line-buffer contents are don't-care.
REQ-030 Reset mid-frame aborts immediately; no partial done; the next start begins a clean frame.

Structure
REQ-031 Package maxpool_pkg SHALL hold the state enum (IDLE, RUN, FLUSH, DONE), width constants derived from MAX_W/MAX_H, and a signed lane-max function.
REQ-032 Sub-module pool_line_buf SHALL hold the MAX_W x LANES*DATA_WIDTH line buffer, with one read port and one write port, same-address write-after-read.

Verification
REQ-033 Stride 2, W = H = 4, lane0 p = x + 4y, other lanes = -p -> 4 outputs; lane0 = 5, 7, 13, 15; lane1 = -0, -2, -8, -10; out_last on the 4th output; done one cycle later.
REQ-034 Stride 1, W = H = 3, lane0 p = x + 3y -> 9 outputs: 4, 5, 5, 7, 8, 8, 7, 8, 8; in_ready drops once per row end and during FLUSH.
REQ-035 Stride 2, W = H = 5 -> 4 outputs; column 4 and row 4 values (set to +32767) never appear in any output.
REQ-036 Stride 2, W = H = 4 with out_ready toggled 1010... -> output values identical to REQ-033; no lost or duplicated beats; out_data stable while stalled.
REQ-037 Mixed-sign: lane values -32768 and 32767 in one window -> output 32767; all-negative window (-5, -3, -9, -7) -> -3.
REQ-038 rst_n pulsed after 6 input beats of a 4x4 frame -> busy = 0 next cycle, no done; a new 4x4 start reproduces REQ-033 exactly.
